// File: rtl/imm_extend_arbiter.sv
// imm_extend_arbiter
// Two requesters share one 16->32 bit immediate extender. The winner of a
// combinational arbitration is loaded into a one-entry output register.
// That register has a valid/ready handshake and is tagged with the winner's id.
module imm_extend_arbiter #(
  parameter logic FAIR = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [15:0] req0_imm,
  input  logic [1:0]  req0_mode,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [15:0] req1_imm,
  input  logic [1:0]  req1_mode,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_id,
  output logic [1:0]  out_mode,
  output logic [7:0]  xfer_cnt
);

  logic        r_out_valid;
  logic [31:0] r_out_data;
  logic        r_out_id;
  logic [1:0]  r_out_mode;
  logic [7:0]  r_xfer_cnt;
  logic        r_last;

  logic        w_can_accept;
  logic        w_grant0;
  logic        w_grant1;
  logic        w_ready0;
  logic        w_ready1;
  logic        w_accept;
  logic [15:0] w_imm;
  logic [1:0]  w_mode;
  logic [31:0] w_ext;

  // Extend a 16-bit immediate according to its mode.
  // Branch mode yields a sign-extended word offset (shifted left by 2).
  function automatic logic [31:0] f_extend(input logic [15:0] imm, input logic [1:0] mode);
    logic [31:0] res;
    case (mode)
      2'b00:   res = {{16{imm[15]}}, imm};
      2'b01:   res = {16'h0000, imm};
      2'b10:   res = {imm, 16'h0000};
      default: res = {{14{imm[15]}}, imm, 2'b00};
    endcase
    return res;
  endfunction

  // Arbitration and datapath select.
  // On a tie, fixed priority favours requester 0; round-robin favours the one not served last.
  always_comb begin
    w_can_accept = !r_out_valid || out_ready;
    w_grant0     = req0_valid && (!req1_valid || !FAIR || r_last);
    w_grant1     = req1_valid && (!req0_valid || (FAIR && !r_last));
    // Ready is forced low while reset is held so nothing appears accepted during reset.
    w_ready0     = w_grant0 && w_can_accept && rst_n;
    w_ready1     = w_grant1 && w_can_accept && rst_n;
    w_accept     = w_ready0 || w_ready1;
    w_imm        = w_grant1 ? req1_imm  : req0_imm;
    w_mode       = w_grant1 ? req1_mode : req0_mode;
    w_ext        = f_extend(w_imm, w_mode);
  end

  // Output register, last-winner tracking and handshake counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= 32'h0;
      r_out_id    <= 1'b0;
      r_out_mode  <= 2'b00;
      r_xfer_cnt  <= 8'd0;
      r_last      <= 1'b1;
    end else begin
      if (r_out_valid && out_ready) begin
        r_xfer_cnt <= r_xfer_cnt + 8'd1;
      end
      if (w_accept) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_ext;
        r_out_id    <= w_grant1;
        r_out_mode  <= w_mode;
        r_last      <= w_grant1;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign req0_ready = w_ready0;
  assign req1_ready = w_ready1;
  assign out_valid  = r_out_valid;
  assign out_data   = r_out_data;
  assign out_id     = r_out_id;
  assign out_mode   = r_out_mode;
  assign xfer_cnt   = r_xfer_cnt;

endmodule

// File: tb/tb_imm_extend_arbiter.sv
// Directed testbench for imm_extend_arbiter.
// Two instances share the same stimulus: u_rr is round-robin and u_fp is fixed priority.
module tb_imm_extend_arbiter;

  logic        clk;
  logic        rst_n;
  logic        req0_valid;
  logic [15:0] req0_imm;
  logic [1:0]  req0_mode;
  logic        req1_valid;
  logic [15:0] req1_imm;
  logic [1:0]  req1_mode;
  logic        out_ready;

  logic        a_req0_ready, a_req1_ready, a_out_valid, a_out_id;
  logic [31:0] a_out_data;
  logic [1:0]  a_out_mode;
  logic [7:0]  a_xfer_cnt;

  logic        b_req0_ready, b_req1_ready, b_out_valid, b_out_id;
  logic [31:0] b_out_data;
  logic [1:0]  b_out_mode;
  logic [7:0]  b_xfer_cnt;

  int passed;
  int total;

  imm_extend_arbiter #(.FAIR(1'b1)) u_rr (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(a_req0_ready), .req0_imm(req0_imm), .req0_mode(req0_mode),
    .req1_valid(req1_valid), .req1_ready(a_req1_ready), .req1_imm(req1_imm), .req1_mode(req1_mode),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_data(a_out_data),
    .out_id(a_out_id), .out_mode(a_out_mode), .xfer_cnt(a_xfer_cnt)
  );

  imm_extend_arbiter #(.FAIR(1'b0)) u_fp (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(b_req0_ready), .req0_imm(req0_imm), .req0_mode(req0_mode),
    .req1_valid(req1_valid), .req1_ready(b_req1_ready), .req1_imm(req1_imm), .req1_mode(req1_mode),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_data(b_out_data),
    .out_id(b_out_id), .out_mode(b_out_mode), .xfer_cnt(b_xfer_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  logic [31:0] mode_exp [4];
  logic [7:0]  exp_cnt;

  initial begin
    passed = 0;
    total  = 0;
    mode_exp[0] = 32'hFFFF8001;
    mode_exp[1] = 32'h00008001;
    mode_exp[2] = 32'h80010000;
    mode_exp[3] = 32'hFFFE0004;

    // Reset with requester 0 valid: ready must stay low.
    rst_n = 1'b0; out_ready = 1'b1;
    req0_valid = 1'b1; req0_imm = 16'h8001; req0_mode = 2'b00;
    req1_valid = 1'b0; req1_imm = 16'h0000; req1_mode = 2'b00;
    tick; tick;
    chk("rst_out_valid", {31'b0, a_out_valid}, 32'd0);
    chk("rst_out_data", a_out_data, 32'h0);
    chk("rst_out_id", {31'b0, a_out_id}, 32'd0);
    chk("rst_out_mode", {30'b0, a_out_mode}, 32'd0);
    chk("rst_xfer_cnt", {24'b0, a_xfer_cnt}, 32'd0);
    chk("rst_req0_ready", {31'b0, a_req0_ready}, 32'd0);

    // Requester 0 alone, all four modes back to back.
    rst_n = 1'b1;
    for (int m = 0; m < 4; m++) begin
      req0_mode = 2'(m);
      #1;
      chk("solo_req0_ready", {31'b0, a_req0_ready}, 32'd1);
      tick;
      $display("solo mode=%0d data=%h id=%0d", m, a_out_data, a_out_id);
      chk("solo_data", a_out_data, mode_exp[m]);
      chk("solo_id", {31'b0, a_out_id}, 32'd0);
      chk("solo_mode", {30'b0, a_out_mode}, 32'(m));
      chk("solo_valid", {31'b0, a_out_valid}, 32'd1);
    end
    req0_valid = 1'b0;
    tick;
    chk("solo_drain_valid", {31'b0, a_out_valid}, 32'd0);
    chk("solo_xfer_cnt", {24'b0, a_xfer_cnt}, 32'd4);

    // Tie after reset: round-robin alternates from 0, fixed priority always picks 0.
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    req0_valid = 1'b1; req0_imm = 16'h0001; req0_mode = 2'b00;
    req1_valid = 1'b1; req1_imm = 16'h0002; req1_mode = 2'b00;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("rr_req0_ready", {31'b0, a_req0_ready}, (k % 2 == 0) ? 32'd1 : 32'd0);
      chk("rr_req1_ready", {31'b0, a_req1_ready}, (k % 2 == 1) ? 32'd1 : 32'd0);
      chk("fp_req0_ready", {31'b0, b_req0_ready}, 32'd1);
      chk("fp_req1_ready", {31'b0, b_req1_ready}, 32'd0);
      tick;
      $display("tie k=%0d rr id=%0d data=%h fp id=%0d data=%h", k, a_out_id, a_out_data, b_out_id, b_out_data);
      chk("rr_id", {31'b0, a_out_id}, (k % 2 == 1) ? 32'd1 : 32'd0);
      chk("rr_data", a_out_data, (k % 2 == 1) ? 32'h2 : 32'h1);
      chk("fp_id", {31'b0, b_out_id}, 32'd0);
      chk("fp_data", b_out_data, 32'h1);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick;
    chk("rr_tie_cnt", {24'b0, a_xfer_cnt}, 32'd4);

    // Backpressure: hold 0x7FFF for 5 cycles while requester 1 waits.
    req0_valid = 1'b1; req0_imm = 16'h7FFF; req0_mode = 2'b01;
    tick;
    req0_valid = 1'b0; out_ready = 1'b0;
    req1_valid = 1'b1; req1_imm = 16'h0003; req1_mode = 2'b00;
    for (int s = 0; s < 5; s++) begin
      #1;
      chk("bp_req1_ready", {31'b0, a_req1_ready}, 32'd0);
      tick;
      $display("stall s=%0d data=%h valid=%0d", s, a_out_data, a_out_valid);
      chk("bp_data", a_out_data, 32'h00007FFF);
      chk("bp_valid", {31'b0, a_out_valid}, 32'd1);
    end
    chk("bp_cnt", {24'b0, a_xfer_cnt}, 32'd4);
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", {31'b0, a_req1_ready}, 32'd1);
    tick;
    chk("bp_new_data", a_out_data, 32'h3);
    chk("bp_new_id", {31'b0, a_out_id}, 32'd1);
    chk("bp_new_valid", {31'b0, a_out_valid}, 32'd1);
    chk("bp_new_cnt", {24'b0, a_xfer_cnt}, 32'd5);

    // Counter wrap: requester 1 keeps the register full and the consumer drains every cycle.
    exp_cnt = 8'd5;
    for (int n = 0; n < 250; n++) begin
      tick;
      exp_cnt = exp_cnt + 8'd1;
    end
    $display("wrap cnt=%0d", a_xfer_cnt);
    chk("wrap_255", {24'b0, a_xfer_cnt}, {24'b0, exp_cnt});
    tick;
    exp_cnt = exp_cnt + 8'd1;
    chk("wrap_0", {24'b0, a_xfer_cnt}, {24'b0, exp_cnt});
    out_ready = 1'b0;
    tick;
    chk("stall_no_inc", {24'b0, a_xfer_cnt}, 32'd0);
    chk("stall_full", {31'b0, a_out_valid}, 32'd1);

    // Reset while full and stalled discards the result and restores the tie winner.
    rst_n = 1'b0;
    tick;
    chk("mid_rst_valid", {31'b0, a_out_valid}, 32'd0);
    chk("mid_rst_data", a_out_data, 32'h0);
    chk("mid_rst_cnt", {24'b0, a_xfer_cnt}, 32'd0);
    chk("mid_rst_req1_ready", {31'b0, a_req1_ready}, 32'd0);
    rst_n = 1'b1;
    req0_valid = 1'b1; req0_imm = 16'h0001; req0_mode = 2'b00;
    #1;
    chk("post_rst_req0_ready", {31'b0, a_req0_ready}, 32'd1);
    chk("post_rst_req1_ready", {31'b0, a_req1_ready}, 32'd0);
    tick;
    $display("post reset id=%0d data=%h", a_out_id, a_out_data);
    chk("post_rst_id", {31'b0, a_out_id}, 32'd0);
    chk("post_rst_data", a_out_data, 32'h1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/imm_extend_arbiter.md
# imm_extend_arbiter

Shares one immediate-extension datapath between two requesters in the MIPS core: requester 0 is the decode stage (ALU/load-store immediates) and requester 1 is the branch-target unit (branch offsets). Each request carries a 16-bit immediate and an extension mode. The block arbitrates, extends the immediate to 32 bits in the selected mode, and presents the result in a one-entry output register with a valid/ready handshake, tagged with the winning requester's id.

## Interface
- FAIR, 1, arbitration policy: 1 = round-robin between requesters, 0 = fixed priority (requester 0 always wins)
- clk  input  1  clock; all state updates on the rising edge
- rst_n  input  1  synchronous reset, active-low
- req0_valid  input  1  requester 0 has a request
- req0_ready  output  1  requester 0 request accepted this cycle
- req0_imm  input  16  requester 0 immediate
- req0_mode  input  2  requester 0 extension mode
- req1_valid  input  1  requester 1 has a request
- req1_ready  output  1  requester 1 request accepted this cycle
- req1_imm  input  16  requester 1 immediate
- req1_mode  input  2  requester 1 extension mode
- out_valid  output  1  output register holds a result
- out_ready  input  1  consumer accepts the result
- out_data  output  32  extended immediate
- out_id  output  1  requester that produced out_data
- out_mode  output  2  mode used for out_data
- xfer_cnt  output  8  count of completed output handshakes, wraps 255 -> 0

## Operation
- Modes (imm = selected 16-bit input):
  - 00 sign: {{16{imm[15]}}, imm}
  - 01 zero: {16'h0000, imm}
  - 10 lui: {imm, 16'h0000}
  - 11 branch: {{14{imm[15]}}, imm, 2'b00}
- Output register states: EMPTY (out_valid=0) and FULL (out_valid=1).
- can_accept = !out_valid | out_ready. The output drains and refills in the same cycle, so back-to-back throughput is 1 result/cycle.
- Grant, evaluated combinationally each cycle:
  - Only one reqN_valid: grant goes to that requester.
  - Both valid, FAIR=0: grant to requester 0.
  - Both valid, FAIR=1: grant to the requester that is not `last`, where `last` is the id of the most recent accepted request.
- reqN_ready = grant_N & can_accept. At most one ready is high per cycle. Ready is never high while reqN_valid=0.
- On acceptance (valid & ready of a requester):
  - out_data, out_id and out_mode load on the next edge; out_valid goes to 1.
  - `last` updates to the granted id. It updates for both FAIR settings but only affects the grant when FAIR=1.
- FULL with out_ready=0: out_data, out_id and out_mode are held stable and no request is accepted.
- FULL with out_ready=1 and no accepted request: out_valid drops to 0 on the next edge.
- xfer_cnt increments on every cycle with out_valid & out_ready, modulo 256.
- Requesters must hold imm and mode stable while valid is high and ready is low. The block does not check this.

## Timing
- Latency: request accepted in cycle N -> result visible at out_valid/out_data in cycle N+1.
- Reset, when rst_n=0 at a rising edge, sets:
  - out_valid=0, out_data=32'h0, out_id=0, out_mode=2'b00, xfer_cnt=0
  - `last`=1, so requester 0 wins the first tie
- During reset, req0_ready=req1_ready=0.
- Reset mid-operation discards a held, unconsumed result with no handshake, and xfer_cnt does not count it.
- reqN_ready depends combinationally on out_ready. There is no combinational path from reqN_valid to out_valid.
- Simultaneous drain and accept in one cycle: xfer_cnt increments and the new result replaces the old one with out_valid staying 1.
- xfer_cnt at 255 plus one handshake -> 0.

## Test plan
- Reset, then requester 0 alone: imm=16'h8001 in each mode 00/01/10/11 with out_ready=1 -> out_data = 32'hFFFF8001, 32'h00008001, 32'h80010000, 32'hFFFE0004 in consecutive cycles, each one cycle after acceptance, out_id=0.
- FAIR=1, both requesters held valid (req0_imm=16'h0001, req1_imm=16'h0002, mode 00), out_ready=1 -> grants alternate 0,1,0,1, starting with 0; out_data alternates 32'h1 and 32'h2; one result per cycle.
- FAIR=0, same stimulus -> only requester 0 is granted, req1_ready stays 0, out_id=0 every cycle.
- Backpressure: result 32'h00007FFF held with out_ready=0 for 5 cycles while req1 is valid -> out_data stable, req1_ready=0 throughout; out_ready=1 -> drain, and req1 accepted in the same cycle.
- Counter wrap: 256 back-to-back handshakes -> xfer_cnt goes 255 -> 0; a stall cycle (out_ready=0) does not increment it.
- Reset asserted while FULL with out_ready=0 -> next cycle out_valid=0, out_data=0, xfer_cnt=0; a subsequent tie grants requester 0.
